// File: rtl/tt_um_uwasic_onboarding_logan_li.sv
// SPI-programmed 16-channel output driver with optional shared PWM (macro PWM_EN).
// Latency: a write shows on the pins 4 clk after nCS rises. No backpressure; malformed frames are dropped.
`timescale 1ns/1ps
module tt_um_uwasic_onboarding_logan_li #(
    parameter int PWM_DIV = 13
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    logic [1:0]  sclk_sync, copi_sync, ncs_sync;
    logic        sclk_prev, ncs_prev;
    logic [15:0] shift_q;
    logic [4:0]  bit_cnt;
    logic [15:0] en_out, en_pwm;
    logic [7:0]  duty;
    logic [15:0] ch_next, ch_q;
    logic        sclk_rise, ncs_fall, ncs_rise, frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            copi_sync <= 2'b00;
            ncs_sync  <= 2'b11;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], ui_in[0]};
            copi_sync <= {copi_sync[0], ui_in[1]};
            ncs_sync  <= {ncs_sync[0], ui_in[2]};
            sclk_prev <= sclk_sync[1];
            ncs_prev  <= ncs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign ncs_fall  = ~ncs_sync[1] & ncs_prev;
    assign ncs_rise  = ncs_sync[1] & ~ncs_prev;

    // Bit count saturates at 17 so any over-length frame stays distinguishable from 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 16'h0000;
            bit_cnt <= 5'd0;
        end else if (ncs_fall) begin
            shift_q <= 16'h0000;
            bit_cnt <= 5'd0;
        end else if (!ncs_sync[1] && sclk_rise) begin
            shift_q <= {shift_q[14:0], copi_sync[1]};
            if (bit_cnt != 5'd17)
                bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign frame_ok = ncs_rise && (bit_cnt == 5'd16) && shift_q[15]
                      && (shift_q[14:8] <= 7'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out <= 16'h0000;
            en_pwm <= 16'h0000;
            duty   <= 8'h00;
        end else if (frame_ok) begin
            case (shift_q[14:8])
                7'd0:    en_out[7:0]  <= shift_q[7:0];
                7'd1:    en_out[15:8] <= shift_q[7:0];
                7'd2:    en_pwm[7:0]  <= shift_q[7:0];
                7'd3:    en_pwm[15:8] <= shift_q[7:0];
                default: duty         <= shift_q[7:0];
            endcase
        end
    end

`ifdef PWM_EN
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    logic [PRE_W-1:0] prescale;
    logic [7:0]       pwm_cnt;
    logic             pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            pwm_cnt  <= 8'h00;
        end else if (prescale == PRE_W'(PWM_DIV - 1)) begin
            prescale <= '0;
            pwm_cnt  <= pwm_cnt + 8'h01;
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    assign pwm     = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty);
    assign ch_next = en_out & (~en_pwm | {16{pwm}});
`else
    logic unused_cfg;
    assign unused_cfg = ^{en_pwm, duty, 1'b0};
    assign ch_next    = en_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ch_q <= 16'h0000;
        else
            ch_q <= ch_next;
    end

    assign uo_out  = ch_q[7:0];
    assign uio_out = ch_q[15:8];
    assign uio_oe  = 8'hFF;

    logic unused_in;
    assign unused_in = ^{ena, uio_in, ui_in[7:3], 1'b0};
endmodule

// File: tb/tb_tt_um_uwasic_onboarding_logan_li.sv
// Scoreboard bench: SPI frames update a register-map model; a monitor compares pins after the write latency.
`timescale 1ns/1ps
module tb_tt_um_uwasic_onboarding_logan_li;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] ui_in;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    tt_um_uwasic_onboarding_logan_li #(.PWM_DIV(13)) dut (
        .ui_in(ui_in), .uo_out(uo_out), .uio_in(8'h00), .uio_out(uio_out),
        .uio_oe(uio_oe), .ena(1'b1), .clk(clk), .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] exp;
        logic [23:0] mask;
        int          due;
        string       name;
    } chk_t;
    chk_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mregs [0:4];

    // Reference: register map semantics straight from the frame rules.
    task automatic model_frame(input int nbits, input logic [16:0] w);
        int addr;
        addr = int'(w[14:8]);
        if (nbits == 16 && w[15] && addr <= 4)
            mregs[addr] = w[7:0];
    endtask

    task automatic push(input string name);
        chk_t c;
        logic [15:0] en, ep, ch, unk;
        en  = {mregs[1], mregs[0]};
        ep  = {mregs[3], mregs[2]};
        unk = 16'h0000;
`ifdef PWM_EN
        if (mregs[4] == 8'hFF)      ch = en;
        else if (mregs[4] == 8'h00) ch = en & ~ep;
        else begin
            ch  = en & ~ep;
            unk = en & ep;
        end
`else
        ch = en;
`endif
        c.exp  = {8'hFF, ch};
        c.mask = ~{8'h00, unk};
        c.due  = cyc + 4;
        c.name = name;
        q.push_back(c);
    endtask

    initial begin : monitor
        chk_t c;
        logic [23:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && cyc >= q[0].due) begin
                c   = q.pop_front();
                act = {uio_oe, uio_out, uo_out};
                n_cmp++;
                if ((act & c.mask) !== (c.exp & c.mask)) begin
                    n_bad++;
                    $display("FAIL %s: got oe/uio/uo=%h want %h (mask %h)", c.name, act, c.exp, c.mask);
                end
            end
        end
    end

    task automatic send_bits(input int nbits, input logic [16:0] w);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = w[i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [16:0] w, input string name);
        send_bits(nbits, w);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        model_frame(nbits, w);
        push(name);
        repeat (10) @(negedge clk);
    endtask

    initial begin : stim
        int nb, addr, k;
        logic [16:0] w;
        for (int i = 0; i < 5; i++) mregs[i] = 8'h00;

        repeat (2) @(negedge clk);
        push("reset");
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(16, 17'h080F0, "wr_lo");
        send_frame(16, 17'h081CC, "wr_hi");
        send_frame(16, 17'h000AA, "read_ignored");
        send_frame(16, 17'h0B0AA, "addr30_ignored");
        send_frame(15, 17'h04012, "short_ignored");
        send_frame(16, 17'h08501, "addr5_ignored");
        send_frame(17, 17'h18033, "long_ignored");
        send_frame(16, 17'h08001, "en0");
        send_frame(16, 17'h08201, "pwm0");
        send_frame(16, 17'h08440, "duty40");
        send_frame(16, 17'h08400, "duty00");
        send_frame(16, 17'h084FF, "dutyFF");

`ifdef PWM_EN
        begin
            int highs, rises;
            logic prev;
            send_frame(16, 17'h08480, "duty80");
            highs = 0; rises = 0; prev = uo_out[0];
            for (int i = 0; i < 256 * 13 * 4; i++) begin
                @(negedge clk);
                if (uo_out[0]) highs++;
                if (uo_out[0] && !prev) rises++;
                prev = uo_out[0];
            end
            n_cmp++;
            if (highs < 6523 || highs > 6789) begin
                n_bad++;
                $display("FAIL pwm_duty: got %0d high cycles want 6523..6789", highs);
            end
            n_cmp++;
            if (rises < 3 || rises > 5) begin
                n_bad++;
                $display("FAIL pwm_period: got %0d rising edges want 3..5", rises);
            end
        end
`endif

        for (int i = 0; i < 30; i++) begin
            k    = $urandom_range(0, 5);
            nb   = (k == 0) ? 15 : (k == 5) ? 17 : 16;
            addr = ($urandom_range(0, 7) == 0) ? 'h30 : $urandom_range(0, 6);
            w    = {$urandom_range(0, 1) == 1'b1 ? 1'b1 : 1'b0,
                    ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                    7'(addr), 8'($urandom)};
            send_frame(nb, w, "random");
        end

        send_bits(8, 17'h000FF);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
        push("reset_mid");
        repeat (6) @(negedge clk);
        ncs = 1'b1; sclk = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16, 17'h08055, "after_reset");

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending checks want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
